// File: rtl/fpu_mul_pkg.sv
// Shared definitions for the FPU mantissa multiplier path.
// Holds the FSM state encoding and the default operand and counter widths.
package fpu_mul_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/products8.sv
// 8-bit partial-product row generator: gates the multiplicand with one multiplier bit.
// Ports:
//   mcand  - 8-bit multiplicand
//   sel    - multiplier bit selecting this row
//   row_c  - combinational row, mcand when sel=1, else 0
module products8 (
  input  logic [7:0] mcand,
  input  logic       sel,
  output logic [7:0] row_c
);

  assign row_c = mcand & {8{sel}};

endmodule

// File: rtl/pp_shift_accumulator.sv
// Iterative unsigned shift-and-add mantissa multiplier.
// Each RUN cycle adds one gated partial-product row into a 2*WIDTH accumulator.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - operands a/b valid; in_ready - stage idle and accepting
//   out_valid  - product valid; out_ready - consumer takes the product
//   product    - registered a*b, held until the next result
// Optional feature macro PP_ACC_EARLY_TERM_EN: leave RUN as soon as the
// remaining multiplier bits are all zero.
module pp_shift_accumulator
  import fpu_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      product_q, product_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   row_c;
  logic               last_c;

  // Partial-product row for the current multiplier bit (unshifted multiplicand)
  if (WIDTH == 8) begin : g_row_p8
    products8 u_products8 (
      .mcand (mcand_q[7:0]),
      .sel   (mplier_q[0]),
      .row_c (row_c)
    );
  end else begin : g_row_and
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign row_c[i] = mcand_q[i] & mplier_q[0];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    last_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_q + (PW'(row_c) << cnt_q);
        mplier_d = mplier_q >> 1;
        last_c   = (cnt_q == LAST_CNT);
`ifdef PP_ACC_EARLY_TERM_EN
        // Remaining multiplier bits all zero: nothing left to add
        if (mplier_d == '0) last_c = 1'b1;
`endif
        if (last_c) begin
          state_d   = ST_DONE;
          product_d = acc_d;
        end else begin
          // Counter stops at the final row so it never passes WIDTH-1
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
